// File: rtl/branch_pkg.sv
// Shared encodings and helpers for the branch resolver: 2-bit BHT counter
// states, their reset value, the saturating update and the PC-to-index map.
package branch_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    localparam logic [1:0] BHT_RESET = WT;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == ST) ? ST : (ctr + 2'd1);
        end else begin
            nxt = (ctr == SNT) ? SNT : (ctr - 2'd1);
        end
        return nxt;
    endfunction

    // Word-aligned PCs: drop the two byte-offset bits, keep idx_bits above them.
    function automatic logic [31:0] bht_index(input logic [63:0] pc, input int unsigned idx_bits);
        logic [63:0] shifted;
        logic [63:0] mask;
        shifted = pc >> 2;
        mask    = (64'd1 << idx_bits) - 64'd1;
        return 32'(shifted & mask);
    endfunction

endpackage

// File: rtl/branch_pred_fifo.sv
// In-flight prediction FIFO with push, pop and a synchronous flush that
// wins over a same-cycle push.
module branch_pred_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    import branch_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rdata   = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty;

    // Pointer and occupancy tracking; flush discards everything at once.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset; contents are only read when occupied.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Checks fetch-time predictions against execute outcomes, raises a one-cycle
// flush with the corrected PC on a wrong direction, and trains a 2-bit BHT.
module branch_resolver #(
    parameter int DEPTH       = 4,
    parameter int BHT_ENTRIES = 64,
    parameter int PC_WIDTH    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic [PC_WIDTH-1:0] pred_pc,
    input  logic                pred_taken,
    output logic                pred_ready,
    input  logic                res_valid,
    input  logic                res_taken,
    input  logic [PC_WIDTH-1:0] res_target,
    output logic                mispredict,
    output logic [PC_WIDTH-1:0] redirect_pc,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                lookup_taken,
    output logic [31:0]         branch_count,
    output logic [31:0]         mispredict_count,
    output logic                res_error
);
    import branch_pkg::*;

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]          r_bht [BHT_ENTRIES];
    logic                r_mispredict;
    logic [PC_WIDTH-1:0] r_redirect_pc;
    logic [31:0]         r_branch_count;
    logic [31:0]         r_mispredict_count;
    logic                r_res_error;

    logic [PC_WIDTH:0]   w_head;
    logic [PC_WIDTH-1:0] w_head_pc;
    logic                w_head_taken;
    logic                w_full;
    logic                w_empty;
    logic                w_resolve;
    logic                w_mismatch;
    logic [31:0]         w_lookup_full;
    logic [31:0]         w_head_full;
    logic [IDX_W-1:0]    w_lookup_idx;
    logic [IDX_W-1:0]    w_head_idx;

    branch_pred_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PC_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (pred_valid && !w_full),
        .i_pop   (w_resolve),
        .i_flush (w_mismatch),
        .i_wdata ({pred_pc, pred_taken}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_pc    = w_head[PC_WIDTH:1];
    assign w_head_taken = w_head[0];
    assign w_resolve    = res_valid && !w_empty;
    assign w_mismatch   = w_resolve && (res_taken != w_head_taken);

    assign w_lookup_full = bht_index(64'(lookup_pc), IDX_W);
    assign w_head_full   = bht_index(64'(w_head_pc), IDX_W);
    assign w_lookup_idx  = w_lookup_full[IDX_W-1:0];
    assign w_head_idx    = w_head_full[IDX_W-1:0];

    // Lookup reads the pre-edge table; a same-cycle training write is not bypassed.
    assign lookup_taken     = r_bht[w_lookup_idx][1];
    assign pred_ready       = !w_full;
    assign mispredict       = r_mispredict;
    assign redirect_pc      = r_redirect_pc;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
    assign res_error        = r_res_error;

    // Resolution outcome: flush pulse, redirect target, counters, error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mispredict       <= 1'b0;
            r_redirect_pc      <= '0;
            r_branch_count     <= 32'd0;
            r_mispredict_count <= 32'd0;
            r_res_error        <= 1'b0;
        end else begin
            r_mispredict <= w_mismatch;
            if (w_mismatch) begin
                r_redirect_pc      <= res_taken ? res_target : (w_head_pc + PC_WIDTH'(4));
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
            if (w_resolve) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (res_valid && w_empty) begin
                r_res_error <= 1'b1;
            end
        end
    end

    // BHT training toward the actual direction of each resolved branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= BHT_RESET;
            end
        end else if (w_resolve) begin
            r_bht[w_head_idx] <= sat_update(r_bht[w_head_idx], res_taken);
        end
    end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Back end of branch prediction. Records each prediction issued at fetch in an in-flight queue and checks it against the actual outcome from execute.
- On a wrong direction it raises a one-cycle mispredict/flush with the correct redirect PC.
- Trains a 2-bit saturating-counter branch history table (BHT) that fetch reads through a combinational lookup port.
- Sits between fetch (prediction source) and execute (branch resolution).

Parameters:
- DEPTH, 4: in-flight prediction queue entries; power of 2, at least 2.
- BHT_ENTRIES, 64: BHT counter entries; power of 2.
- PC_WIDTH, 32: PC width.

Ports:
- clk  in  1  global clock
- rst  in  1  global reset; synchronous, active-high
- pred_valid  in  1  fetch issues a prediction for a branch this cycle
- pred_pc  in  PC_WIDTH  PC of the predicted branch
- pred_taken  in  1  predicted direction
- pred_ready  out  1  queue can accept a prediction
- res_valid  in  1  execute resolves the oldest in-flight branch
- res_taken  in  1  actual direction
- res_target  in  PC_WIDTH  computed taken target
- mispredict  out  1  registered one-cycle flush pulse
- redirect_pc  out  PC_WIDTH  correct next PC; valid while mispredict=1
- lookup_pc  in  PC_WIDTH  fetch BHT lookup address
- lookup_taken  out  1  BHT prediction for lookup_pc (combinational)
- branch_count  out  32  resolved branches
- mispredict_count  out  32  mispredictions
- res_error  out  1  sticky flag: resolve arrived while the queue was empty

Behaviour:
- Reset:
  - Queue empty.
  - mispredict, redirect_pc, branch_count, mispredict_count and res_error are all 0.
  - Every BHT entry is reset to 2'b10 (weakly taken), so post-reset behaviour matches the existing always-taken policy.
- Queue:
  - FIFO of {pc, taken}.
  - pred_ready = !full.
  - A push happens when pred_valid && pred_ready.
  - No push when full, even if a pop happens in the same cycle.
- Resolve:
  - When res_valid && !empty, pop the head and compare res_taken with head.taken.
  - On a match: mispredict=0 next cycle.
  - On a mismatch: at the next edge, mispredict=1 and redirect_pc = res_taken ? res_target : head.pc + 4 (wraps modulo 2^PC_WIDTH).
  - Latency from resolve to the mispredict pulse is 1 cycle. The pulse lasts exactly 1 cycle.
- Flush:
  - A mispredicting resolve empties the whole queue at the same edge, discarding all younger wrong-path entries.
  - A push in that same cycle is dropped.
- Empty resolve:
  - res_valid with an empty queue sets res_error (held until rst).
  - No pop, no BHT update, no count change.
- BHT:
  - Index = pc[log2(BHT_ENTRIES)+1:2].
  - lookup_taken = bht[index(lookup_pc)][1].
  - On every valid resolve, bht[index(head.pc)] saturates toward res_taken: increment if taken, capped at 11; decrement if not taken, floored at 00.
  - The write takes effect at the edge. A same-cycle lookup of the same index returns the old value (no bypass).
- Counters:
  - branch_count increments on every valid resolve.
  - mispredict_count increments on every mismatch.
  - Both wrap at 2^32.
- Simultaneous push and non-mispredicting resolve: both proceed and occupancy is unchanged.
- Reset mid-operation: the queue is discarded, any pending pulse is suppressed, and the BHT is reinitialised.

Decomposition:
- Package branch_pkg holds:
  - counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11
  - BHT_RESET=WT
  - saturating-update function
  - BHT index function
- One sub-module, branch_pred_fifo: parameterised FIFO with push, pop, synchronous flush, full and empty.
- Compare logic, BHT and counters stay in branch_resolver.

Test Plan:
- Reset, then lookup_pc=0x100 -> lookup_taken=1. All counts 0, pred_ready=1, mispredict=0.
- Push pc=0x100 taken=1, then resolve taken=1 -> no mispredict. branch_count=1, bht[0x40 mod 64] goes to 11, lookup_taken=1.
- Push pc=0x200 taken=1, then resolve taken=0 -> next cycle mispredict=1 for one cycle, redirect_pc=0x204, mispredict_count=1. After two such resolves, lookup_taken for 0x200 = 0.
- Push pc=0x300 taken=0, then resolve taken=1 with res_target=0x380 -> redirect_pc=0x380.
- Push 4 entries -> pred_ready=0 and a 5th push is ignored. Then resolve a mispredict on the head -> queue empty, pred_ready=1, and a same-cycle push is dropped.
- Resolve on an empty queue -> res_error=1 and stays 1. branch_count unchanged. rst clears it.
